// File: rtl/program_loader.sv
// program_loader
//   Copies a length-prefixed program image from a source (BIOS/storage)
//   into instruction memory. The word at src_base holds the length N;
//   the N words that follow are written to imem addresses 0..N-1.
//   Lengths above the imem capacity are clamped, and err is raised.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   start            begin a load (accepted only in IDLE/DONE)
//   hlt              pause: no new source request while high
//   src_base         source address of the length word, latched with start
//   src_req/addr     one-cycle source read request and its address
//   src_valid/data   source response strobe and data (latency >= 1)
//   imem_we/addr/wdata  registered instruction-memory write port
//   busy, done       load in progress / load finished (level)
//   handoff          one-cycle pulse on entry to DONE
//   err              length overflow, sticky until next accepted start
module program_loader #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned SRC_ADDR_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      hlt,
    input  logic [SRC_ADDR_WIDTH-1:0] src_base,
    output logic                      src_req,
    output logic [SRC_ADDR_WIDTH-1:0] src_addr,
    input  logic                      src_valid,
    input  logic [DATA_WIDTH-1:0]     src_data,
    output logic                      imem_we,
    output logic [ADDR_WIDTH-1:0]     imem_addr,
    output logic [DATA_WIDTH-1:0]     imem_wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      handoff,
    output logic                      err
);

    // count/len carry one extra bit so a full-capacity image does not wrap
    localparam int unsigned          CW    = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]         CAP   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [DATA_WIDTH-1:0] CAP_D = DATA_WIDTH'(CAP);

    typedef enum logic [2:0] {
        IDLE,
        LEN_REQ,
        LEN_WAIT,
        DAT_REQ,
        DAT_WAIT,
        DONE
    } state_t;

    state_t                    state;
    state_t                    next_state;
    logic [SRC_ADDR_WIDTH-1:0] base;
    logic [CW-1:0]             count;
    logic [CW-1:0]             len;
    logic                      len_vld;

    always_comb begin
        next_state = state;
        src_req    = 1'b0;
        src_addr   = '0;
        case (state)
            IDLE, DONE: begin
                if (start) next_state = LEN_REQ;
            end
            LEN_REQ: begin
                if (!hlt) begin
                    src_req    = 1'b1;
                    src_addr   = base;
                    next_state = LEN_WAIT;
                end
            end
            LEN_WAIT: begin
                // length is registered first, then decided on the next cycle
                if (len_vld) next_state = (len == '0) ? DONE : DAT_REQ;
            end
            DAT_REQ: begin
                if (!hlt) begin
                    src_req    = 1'b1;
                    src_addr   = base + SRC_ADDR_WIDTH'(1) + SRC_ADDR_WIDTH'(count);
                    next_state = DAT_WAIT;
                end
            end
            DAT_WAIT: begin
                if (src_valid) next_state = ((count + CW'(1)) < len) ? DAT_REQ : DONE;
            end
            default: next_state = IDLE;
        endcase
        busy = (state != IDLE) && (state != DONE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            base       <= '0;
            count      <= '0;
            len        <= '0;
            len_vld    <= 1'b0;
            err        <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            handoff    <= 1'b0;
        end else begin
            state   <= next_state;
            imem_we <= 1'b0;
            handoff <= (next_state == DONE) && (state != DONE);
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        base    <= src_base;
                        count   <= '0;
                        len     <= '0;
                        len_vld <= 1'b0;
                        err     <= 1'b0;
                    end
                end
                LEN_WAIT: begin
                    if (src_valid && !len_vld) begin
                        len_vld <= 1'b1;
                        if (src_data > CAP_D) begin
                            len <= CAP;
                            err <= 1'b1;
                        end else begin
                            len <= src_data[CW-1:0];
                        end
                    end
                end
                DAT_WAIT: begin
                    if (src_valid) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= count[ADDR_WIDTH-1:0];
                        imem_wdata <= src_data;
                        count      <= count + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//   Drives program_loader (ADDR_WIDTH=4) from a behavioural source memory
//   with configurable latency. Expected source requests and imem writes are
//   queued when a load is set up and popped as the DUT produces them.
module tb_program_loader;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;
    localparam int unsigned SW = 16;
    localparam int unsigned CAPN = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          hlt;
    logic [SW-1:0] src_base;
    logic          src_req;
    logic [SW-1:0] src_addr;
    logic          src_valid;
    logic [DW-1:0] src_data;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic          busy;
    logic          done;
    logic          handoff;
    logic          err;

    program_loader #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .SRC_ADDR_WIDTH(SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .hlt       (hlt),
        .src_base  (src_base),
        .src_req   (src_req),
        .src_addr  (src_addr),
        .src_valid (src_valid),
        .src_data  (src_data),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .busy      (busy),
        .done      (done),
        .handoff   (handoff),
        .err       (err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [SW-1:0] base;
        int unsigned   len;
        int unsigned   lat;
        logic [DW-1:0] d0;
        int unsigned   hold;
        logic          mid;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
    } wr_t;

    vec_t          vecs [9];
    wr_t           exp_wr [$];
    logic [SW-1:0] exp_req [$];
    logic [DW-1:0] smem [0:65535];

    int unsigned   checks = 0;
    int unsigned   errors = 0;

    // source model state
    int unsigned   cur_lat = 1;
    int unsigned   cur_hold = 0;
    logic [SW-1:0] hold_addr = '0;
    logic          pend = 1'b0;
    logic [SW-1:0] pend_addr = '0;
    int unsigned   due = 0;
    int unsigned   hold_left = 0;
    int unsigned   last_valid_cyc = 0;
    int unsigned   ho_count = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Source responder and output monitor: sample at negedge, drive at posedge+1
    initial begin
        wr_t w;
        hlt       = 1'b0;
        src_valid = 1'b0;
        src_data  = '0;
        forever begin
            @(negedge clk);
            if (src_req === 1'b1) begin
                chk("req_while_hlt", 64'(hlt), 64'(0));
                chk("req_expected", 64'(exp_req.size() > 0), 64'(1));
                if (exp_req.size() > 0) chk("req_addr", 64'(src_addr), 64'(exp_req.pop_front()));
                chk("one_outstanding", 64'(pend), 64'(0));
                pend      = 1'b1;
                pend_addr = src_addr;
                due       = cyc + cur_lat;
            end
            if (imem_we === 1'b1) begin
                chk("wr_expected", 64'(exp_wr.size() > 0), 64'(1));
                if (exp_wr.size() > 0) begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", 64'(imem_addr), 64'(w.addr));
                    chk("wr_data", 64'(imem_wdata), 64'(w.data));
                    chk("handoff_with_last_wr", 64'(handoff), 64'(w.last));
                end
            end else if (handoff === 1'b1) begin
                chk("zero_len_handoff_delay", 64'(cyc - last_valid_cyc), 64'(2));
            end
            if (handoff === 1'b1) ho_count++;

            @(posedge clk);
            #1;
            src_valid = 1'b0;
            src_data  = '0;
            if (hold_left > 0) begin
                hlt = 1'b1;
                // stray strobe while paused in DAT_REQ must be ignored
                if (hold_left == cur_hold - 1) begin
                    src_valid = 1'b1;
                    src_data  = 32'hBAD0_0000;
                end
                hold_left--;
            end else begin
                hlt = 1'b0;
            end
            if (pend && cyc >= due) begin
                src_valid      = 1'b1;
                src_data       = smem[pend_addr];
                pend           = 1'b0;
                last_valid_cyc = cyc;
                if (cur_hold > 0 && pend_addr == hold_addr) hold_left = cur_hold;
            end
        end
    end

    task automatic prep(input vec_t v);
        int unsigned   n;
        logic [SW-1:0] a;
        n = (v.len > CAPN) ? CAPN : v.len;
        smem[v.base] = DW'(v.len);
        exp_req.push_back(v.base);
        for (int unsigned i = 0; i < n; i++) begin
            a       = v.base + SW'(1 + i);
            smem[a] = v.d0 + DW'(i);
            exp_req.push_back(a);
            exp_wr.push_back('{addr: AW'(i), data: v.d0 + DW'(i), last: (i == n - 1)});
        end
        cur_lat   = v.lat;
        cur_hold  = v.hold;
        hold_addr = v.base + SW'(1);
    endtask

    task automatic pulse_start(input logic [SW-1:0] b);
        @(posedge clk);
        #1;
        src_base = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        src_base = ~b;
    endtask

    task automatic run_vec(input vec_t v);
        int unsigned ho0;
        logic        got;
        prep(v);
        ho0 = ho_count;
        pulse_start(v.base);
        @(negedge clk);
        chk("after_start_busy_done_err", 64'({busy, done, err}), 64'(3'b100));
        if (v.mid) begin
            repeat (3) @(posedge clk);
            #1;
            src_base = v.base + 16'h0100;
            start    = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            if (done === 1'b1) got = 1'b1;
        end
        chk("done_reached", 64'(got), 64'(1));
        @(negedge clk);
        chk("final_busy_done", 64'({busy, done}), 64'(2'b01));
        chk("err_flag", 64'(err), 64'(v.len > CAPN));
        chk("writes_outstanding", 64'(exp_wr.size()), 64'(0));
        chk("reqs_outstanding", 64'(exp_req.size()), 64'(0));
        chk("handoff_pulses", 64'(ho_count - ho0), 64'(1));
        exp_wr.delete();
        exp_req.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        rv;
        logic        got;
        int unsigned quiet;

        rst      = 1'b1;
        start    = 1'b0;
        src_base = '0;

        vecs[0] = '{base: 16'h0100, len: 3,  lat: 2, d0: 32'h0000_000A, hold: 0, mid: 1'b0};
        vecs[1] = '{base: 16'h0100, len: 3,  lat: 2, d0: 32'h0000_000A, hold: 5, mid: 1'b0};
        vecs[2] = '{base: 16'h0200, len: 0,  lat: 3, d0: 32'h0,         hold: 0, mid: 1'b0};
        vecs[3] = '{base: 16'h0300, len: 20, lat: 1, d0: 32'h3000_0000, hold: 0, mid: 1'b0};
        vecs[4] = '{base: 16'h0400, len: 16, lat: 1, d0: 32'h4000_0000, hold: 0, mid: 1'b0};
        vecs[5] = '{base: 16'h0500, len: 17, lat: 2, d0: 32'h5000_0000, hold: 0, mid: 1'b0};
        vecs[6] = '{base: 16'hFFFE, len: 4,  lat: 3, d0: 32'h6000_0000, hold: 0, mid: 1'b0};
        vecs[7] = '{base: 16'h0700, len: 5,  lat: 5, d0: 32'h7000_0000, hold: 0, mid: 1'b1};
        vecs[8] = '{base: 16'h0900, len: 1,  lat: 1, d0: 32'h9999_0001, hold: 0, mid: 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            64'({src_req, src_addr, imem_we, imem_addr, imem_wdata, busy, done, handoff, err}), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // reset while a data response is outstanding
        rv = '{base: 16'h0A00, len: 3, lat: 4, d0: 32'h5555_0000, hold: 0, mid: 1'b0};
        prep(rv);
        pulse_start(rv.base);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (imem_we === 1'b1) got = 1'b1;
        end
        chk("first_write_before_rst", 64'(got), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("outputs_after_mid_rst",
            64'({src_req, src_addr, imem_we, imem_addr, imem_wdata, busy, done, handoff, err}), 64'(0));
        exp_wr.delete();
        exp_req.delete();
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            quiet += int'(imem_we) + int'(src_req);
        end
        chk("quiet_after_rst", 64'(quiet), 64'(0));
        chk("idle_after_rst", 64'({busy, done}), 64'(0));

        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
